dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder for the MEM stage: accepts one load/store,
// waits LATENCY cycles, then presents the result until the requester consumes it.
module dmem_responder #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned AW      = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           write_q, write_d;
   logic [AW+1:0]  addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;
   logic [31:0]    mem_q [DEPTH];

   logic           form_result;
   logic           mem_we;
   logic           sel_write;
   logic [AW+1:0]  sel_addr;
   logic [31:0]    sel_wdata;
   logic [AW-1:0]  sel_idx;
   logic           unused_addr_bits;

   // Address bits above the memory window are deliberately ignored (modulo wrap).
   assign unused_addr_bits = ^req_addr[31:AW+2];

   // With LATENCY=0 the result is formed on the accepting edge, straight from the inputs.
   assign sel_write = (state_q == S_IDLE) ? req_write           : write_q;
   assign sel_addr  = (state_q == S_IDLE) ? req_addr[AW+1:0]    : addr_q;
   assign sel_wdata = (state_q == S_IDLE) ? req_wdata           : wdata_q;
   assign sel_idx   = sel_addr[AW+1:2];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      form_result = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr[AW+1:0];
               wdata_d = req_wdata;
               if (LATENCY == 0) begin
                  state_d     = S_RESP;
                  form_result = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d     = S_RESP;
               form_result = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      if (form_result) begin
         if (sel_addr[1:0] != 2'b00) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
         end else if (sel_write) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            mem_we  = 1'b1;
         end else begin
            rdata_d = mem_q[sel_idx];
            err_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Reset must clear every word, so the array lives in flops rather than block RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (mem_we) begin
         mem_q[sel_idx] <= sel_wdata;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A (LATENCY=2) checked through a response scoreboard,
// instance B (LATENCY=0) checked for back-to-back throughput.
module tb_dmem_responder;

   localparam int LAT_A = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_ready, a_resp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
   logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      int          id;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.LATENCY(LAT_A), .AW(6)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (a_req_valid),
      .req_write  (a_req_write),
      .req_addr   (a_req_addr),
      .req_wdata  (a_req_wdata),
      .req_ready  (a_req_ready),
      .resp_valid (a_resp_valid),
      .resp_ready (a_resp_ready),
      .resp_rdata (a_resp_rdata),
      .resp_err   (a_resp_err)
   );

   dmem_responder #(.LATENCY(0), .AW(6)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (b_req_valid),
      .req_write  (b_req_write),
      .req_addr   (b_req_addr),
      .req_wdata  (b_req_wdata),
      .req_ready  (b_req_ready),
      .resp_valid (b_resp_valid),
      .resp_ready (b_resp_ready),
      .resp_rdata (b_resp_rdata),
      .resp_err   (b_resp_err)
   );

   // Scoreboard monitor: compares each consumed response against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && a_resp_valid && a_resp_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_resp got rdata=%h err=%b required no response", a_resp_rdata, a_resp_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (a_resp_rdata !== e.rdata || a_resp_err !== e.err) begin
               n_bad++;
               $display("FAIL vec%0d_data got rdata=%h err=%b required rdata=%h err=%b",
                        e.id, a_resp_rdata, a_resp_err, e.rdata, e.err);
            end else begin
               $display("vec%0d ok rdata=%h err=%b", e.id, a_resp_rdata, a_resp_err);
            end
            n_vec++;
            if (cyc != e.due) begin
               n_bad++;
               $display("FAIL vec%0d_timing got cycle=%0d required cycle=%0d", e.id, cyc, e.due);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h required=%h", nm, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int stall,
                        input bit expect_resp, input int id);
      int t;
      t = 0;
      while (!a_req_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!a_req_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL vec%0d_accept_timeout got req_ready=0 required req_ready=1", id);
         return;
      end
      a_req_valid = 1'b1;
      a_req_write = w;
      a_req_addr  = a;
      a_req_wdata = wd;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      a_req_write = 1'b0;
      if (expect_resp) exp_q.push_back('{rdata: er, err: ee, due: cyc + LAT_A + stall, id: id});
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout got pending=%0d required pending=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 1;
      b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(a_req_ready), 32'd1);
      chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
      chk("rst_rdata", a_resp_rdata, 32'd0);
      chk("rst_err", 32'(a_resp_err), 32'd0);
      rst_n = 1'b1;

      // LATENCY=0: a store, then loads held back-to-back with resp_ready=1.
      b_req_valid = 1; b_req_write = 1; b_req_addr = 32'h4; b_req_wdata = 32'hCAFE0001;
      @(posedge clk); #1;
      chk("b_store_valid", 32'(b_resp_valid), 32'd1);
      chk("b_store_rdata", b_resp_rdata, 32'd0);
      chk("b_store_err", 32'(b_resp_err), 32'd0);
      b_req_write = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b_b2b_valid%0d", k), 32'(b_resp_valid), 32'(k % 2));
         chk($sformatf("b_b2b_ready%0d", k), 32'(b_req_ready), 32'(1 - (k % 2)));
         if (k % 2 == 1) chk($sformatf("b_b2b_rdata%0d", k), b_resp_rdata, 32'hCAFE0001);
      end
      b_req_valid = 0;
      $display("lat0 back-to-back sequence done");

      issue(0, 32'h10,  32'h0,        32'h0,        0, 0, 1, 1);
      issue(1, 32'h24,  32'hDEADBEEF, 32'h0,        0, 0, 1, 2);
      issue(0, 32'h24,  32'h0,        32'hDEADBEEF, 0, 0, 1, 3);
      issue(0, 32'h124, 32'h0,        32'hDEADBEEF, 0, 0, 1, 4);
      issue(1, 32'h26,  32'h12345678, 32'h0,        1, 0, 1, 5);
      issue(0, 32'h24,  32'h0,        32'hDEADBEEF, 0, 0, 1, 6);
      issue(0, 32'h27,  32'h0,        32'h0,        1, 0, 1, 7);
      issue(1, 32'hFC,  32'hA5A5A5A5, 32'h0,        0, 0, 1, 8);
      issue(0, 32'h1FC, 32'h0,        32'hA5A5A5A5, 0, 0, 1, 9);
      issue(1, 32'h100, 32'h11110000, 32'h0,        0, 0, 1, 10);
      issue(0, 32'h0,   32'h0,        32'h11110000, 0, 0, 1, 11);
      issue(0, 32'h10,  32'h0,        32'h0,        0, 0, 1, 12);
      drain();

      // Backpressure: five RESP cycles with resp_ready low.
      a_resp_ready = 0;
      issue(0, 32'h24, 32'h0, 32'hDEADBEEF, 0, 5, 1, 13);
      repeat (LAT_A) begin @(posedge clk); #1; end
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall_valid%0d", k), 32'(a_resp_valid), 32'd1);
         chk($sformatf("stall_req_ready%0d", k), 32'(a_req_ready), 32'd0);
         chk($sformatf("stall_rdata%0d", k), a_resp_rdata, 32'hDEADBEEF);
         @(posedge clk); #1;
      end
      a_resp_ready = 1;
      @(posedge clk); #1;
      chk("stall_release_req_ready", 32'(a_req_ready), 32'd1);
      chk("stall_release_valid", 32'(a_resp_valid), 32'd0);
      drain();

      // Reset mid-WAIT of a store: outputs clear at once and the store is dropped.
      issue(1, 32'h08, 32'h55AA55AA, 32'h0, 0, 0, 0, 14);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(a_req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(a_resp_valid), 32'd0);
      chk("midrst_rdata", a_resp_rdata, 32'd0);
      chk("midrst_err", 32'(a_resp_err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue(0, 32'h08, 32'h0, 32'h0, 0, 0, 1, 15);
      issue(0, 32'h24, 32'h0, 32'h0, 0, 0, 1, 16);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
